// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller: write pointer, full/almost-full/fill status,
// zero-latency write strobe and a sticky overflow flag.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH         = 5,
  parameter int ALMOST_FULL_THRESH = 30
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH:0]   i_rd_address,
  output logic [ADDR_WIDTH:0]   o_wr_address,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_fill_level,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Threshold fits in ADDR_WIDTH+1 bits since it is at most DEPTH.
  localparam logic [ADDR_WIDTH:0] THRESH_V = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);

  typedef enum logic {
    ST_OK  = 1'b0,
    ST_OVF = 1'b1
  } state_e;

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  state_e              state_q, state_d;
  logic                full;
  logic                wr_en;
  logic [ADDR_WIDTH:0] fill;

  // Status derived combinationally from the current pointer pair. Full when
  // the wrap bits differ but the memory indices match.
  always_comb begin
    full  = (wr_ptr_q[ADDR_WIDTH] != i_rd_address[ADDR_WIDTH]) &&
            (wr_ptr_q[ADDR_WIDTH-1:0] == i_rd_address[ADDR_WIDTH-1:0]);
    fill  = wr_ptr_q - i_rd_address;
    // Reset gates the strobe so nothing reaches storage while it is held.
    wr_en = i_wr_req && !full && !i_flush && !i_rst;
  end

  // Next write pointer: flush snaps to the read pointer (empty), otherwise
  // advance on each accepted write; wraps naturally at 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (i_flush)
      wr_ptr_d = i_rd_address;
    else if (wr_en)
      wr_ptr_d = wr_ptr_q + 1'b1;
  end

  // Write pointer register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) wr_ptr_q <= '0;
    else       wr_ptr_q <= wr_ptr_d;
  end

  // Overflow FSM next state: a rejected request while full latches OVF;
  // only flush (or reset) returns to OK. Flush wins over a same-cycle request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OK:   if (!i_flush && i_wr_req && full) state_d = ST_OVF;
      ST_OVF:  if (i_flush) state_d = ST_OK;
      default: state_d = ST_OK;
    endcase
  end

  // Overflow FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_OK;
    else       state_q <= state_d;
  end

  // Output mapping.
  always_comb begin
    o_wr_address  = wr_ptr_q;
    o_mem_addr    = wr_ptr_q[ADDR_WIDTH-1:0];
    o_mem_wr_en   = wr_en;
    o_full        = full;
    o_fill_level  = fill;
    o_almost_full = (fill >= THRESH_V);
    o_overflow    = (state_q == ST_OVF);
  end

  // DEPTH only documents the pointer range; keep it referenced.
  logic unused_depth;
  assign unused_depth = (DEPTH == 0);

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at ADDR_WIDTH=5, threshold 30, depth 32.
module tb_fifo_wr_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_wr_req = 1'b0;
  logic [5:0] i_rd_address = '0;
  logic [5:0] o_wr_address;
  logic [4:0] o_mem_addr;
  logic       o_mem_wr_en;
  logic       o_full;
  logic       o_almost_full;
  logic [5:0] o_fill_level;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;

  fifo_wr_ctrl #(.ADDR_WIDTH(5), .ALMOST_FULL_THRESH(30)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_wr_req(i_wr_req),
    .i_rd_address(i_rd_address), .o_wr_address(o_wr_address),
    .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en), .o_full(o_full),
    .o_almost_full(o_almost_full), .o_fill_level(o_fill_level),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_wr_req = 1'b1;
    i_rd_address = 6'd0;
    #1 i_rst = 1'b1;
    #1;
    checks++; if (o_wr_address !== 6'd0) begin errors++; $display("FAIL rst_wr: got %0d exp 0", o_wr_address); end
    checks++; if (o_fill_level !== 6'd0) begin errors++; $display("FAIL rst_fill: got %0d exp 0", o_fill_level); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b exp 0", o_full); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 0", o_overflow); end
    checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b exp 0", o_almost_full); end
    checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b exp 0", o_mem_wr_en); end
    tick();
    checks++; if (o_wr_address !== 6'd0) begin errors++; $display("FAIL rst_hold_wr: got %0d exp 0", o_wr_address); end
    i_wr_req = 1'b0;
    i_rst = 1'b0;
  endtask

  task automatic test_fill();
    i_rd_address = 6'd0;
    i_wr_req = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++; if (o_wr_address !== 6'(k)) begin errors++; $display("FAIL fill_wr[%0d]: got %0d exp %0d", k, o_wr_address, k); end
      checks++; if (o_fill_level !== 6'(k)) begin errors++; $display("FAIL fill_lvl[%0d]: got %0d exp %0d", k, o_fill_level, k); end
      checks++; if (o_almost_full !== (k >= 30)) begin errors++; $display("FAIL fill_afull[%0d]: got %b exp %b", k, o_almost_full, (k >= 30)); end
      checks++; if (o_full !== (k == 32)) begin errors++; $display("FAIL fill_full[%0d]: got %b exp %b", k, o_full, (k == 32)); end
    end
    i_wr_req = 1'b0;
    #1;
    checks++; if (o_mem_addr !== 5'd0) begin errors++; $display("FAIL fill_memaddr: got %0d exp 0", o_mem_addr); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf: got %b exp 0", o_overflow); end
  endtask

  task automatic test_overflow();
    i_wr_req = 1'b1;
    #1;
    checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL ovf_wren: got %b exp 0", o_mem_wr_en); end
    tick();
    i_wr_req = 1'b0;
    #1;
    checks++; if (o_wr_address !== 6'd32) begin errors++; $display("FAIL ovf_wr: got %0d exp 32", o_wr_address); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", o_overflow); end
    i_rd_address = 6'd5;
    #1;
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL ovf_rd_full: got %b exp 0", o_full); end
    checks++; if (o_fill_level !== 6'd27) begin errors++; $display("FAIL ovf_rd_fill: got %0d exp 27", o_fill_level); end
    checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL ovf_rd_afull: got %b exp 0", o_almost_full); end
    i_wr_req = 1'b1;
    tick();
    i_wr_req = 1'b0;
    checks++; if (o_wr_address !== 6'd33) begin errors++; $display("FAIL ovf_accept_wr: got %0d exp 33", o_wr_address); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", o_overflow); end
  endtask

  task automatic test_flush();
    i_rd_address = 6'd12;
    i_flush = 1'b1;
    i_wr_req = 1'b1;
    #1;
    checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL flush_wren: got %b exp 0", o_mem_wr_en); end
    tick();
    i_flush = 1'b0;
    i_wr_req = 1'b0;
    #1;
    checks++; if (o_wr_address !== 6'd12) begin errors++; $display("FAIL flush_wr: got %0d exp 12", o_wr_address); end
    checks++; if (o_fill_level !== 6'd0) begin errors++; $display("FAIL flush_fill: got %0d exp 0", o_fill_level); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b exp 0", o_overflow); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL flush_full: got %b exp 0", o_full); end
  endtask

  task automatic test_wrap();
    i_rd_address = 6'd63;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_rd_address = 6'd60;
    #1;
    checks++; if (o_wr_address !== 6'd63) begin errors++; $display("FAIL wrap_pre_wr: got %0d exp 63", o_wr_address); end
    checks++; if (o_fill_level !== 6'd3) begin errors++; $display("FAIL wrap_pre_fill: got %0d exp 3", o_fill_level); end
    i_wr_req = 1'b1;
    #1;
    checks++; if (o_mem_wr_en !== 1'b1) begin errors++; $display("FAIL wrap_wren: got %b exp 1", o_mem_wr_en); end
    tick();
    i_wr_req = 1'b0;
    #1;
    checks++; if (o_wr_address !== 6'd0) begin errors++; $display("FAIL wrap_wr: got %0d exp 0", o_wr_address); end
    checks++; if (o_fill_level !== 6'd4) begin errors++; $display("FAIL wrap_fill: got %0d exp 4", o_fill_level); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL wrap_full: got %b exp 0", o_full); end
  endtask

  // Read pointer advances on the same edge that accepts a write.
  task automatic test_simul_rw();
    i_rd_address = 6'd40;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_rd_address = 6'd9;
    #1;
    checks++; if (o_fill_level !== 6'd31) begin errors++; $display("FAIL simul_pre_fill: got %0d exp 31", o_fill_level); end
    checks++; if (o_almost_full !== 1'b1) begin errors++; $display("FAIL simul_pre_afull: got %b exp 1", o_almost_full); end
    i_wr_req = 1'b1;
    tick();
    i_rd_address = 6'd10;
    i_wr_req = 1'b0;
    #1;
    checks++; if (o_wr_address !== 6'd41) begin errors++; $display("FAIL simul_wr: got %0d exp 41", o_wr_address); end
    checks++; if (o_fill_level !== 6'd31) begin errors++; $display("FAIL simul_fill: got %0d exp 31", o_fill_level); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL simul_full: got %b exp 0", o_full); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b exp 0", o_overflow); end
    i_rd_address = 6'd9;
    #1;
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL simul_full_bound: got %b exp 1", o_full); end
    checks++; if (o_fill_level !== 6'd32) begin errors++; $display("FAIL simul_fill_bound: got %0d exp 32", o_fill_level); end
  endtask

  task automatic test_reset_midburst();
    i_rd_address = 6'd16;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_wr_req = 1'b1;
    tick();
    checks++; if (o_wr_address !== 6'd17) begin errors++; $display("FAIL mid_pre_wr: got %0d exp 17", o_wr_address); end
    #2 i_rst = 1'b1;
    #1;
    checks++; if (o_wr_address !== 6'd0) begin errors++; $display("FAIL mid_async_wr: got %0d exp 0", o_wr_address); end
    checks++; if (o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wren: got %b exp 0", o_mem_wr_en); end
    tick();
    checks++; if (o_wr_address !== 6'd0) begin errors++; $display("FAIL mid_hold_wr: got %0d exp 0", o_wr_address); end
    i_rst = 1'b0;
    i_rd_address = 6'd0;
    #1;
    checks++; if (o_fill_level !== 6'd0) begin errors++; $display("FAIL mid_fill: got %0d exp 0", o_fill_level); end
    tick();
    i_wr_req = 1'b0;
    checks++; if (o_wr_address !== 6'd1) begin errors++; $display("FAIL mid_resume_wr: got %0d exp 1", o_wr_address); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_flush();
    test_wrap();
    test_simul_rw();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish exp finish by 20000");
    $fatal(1);
  end

endmodule
